// File: rtl/traffic_sequencer_if.sv
// traffic_sequencer_if
//   Signal bundle between the tick divider / pedestrian button / traffic
//   sensors and the intersection phase controller.
//   master : sequencing source (drives tick, ped_req, traffic levels[, night])
//   slave  : traffic_sequencer (drives lamps, walk, ped_pending, counter,
//            cycle_start)
//   Optional: NIGHT_FLASH_EN adds the night-mode request line.
interface traffic_sequencer_if;
    logic       tick;
    logic       ped_req;
    logic [2:0] main_traffic_in;
    logic [2:0] side_traffic_in;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_pending;
    logic [5:0] counter;
    logic       cycle_start;
`ifdef NIGHT_FLASH_EN
    logic       night;

    modport master (
        output tick, ped_req, main_traffic_in, side_traffic_in, night,
        input  main_light, side_light, walk, ped_pending, counter, cycle_start
    );
    modport slave (
        input  tick, ped_req, main_traffic_in, side_traffic_in, night,
        output main_light, side_light, walk, ped_pending, counter, cycle_start
    );
`else
    modport master (
        output tick, ped_req, main_traffic_in, side_traffic_in,
        input  main_light, side_light, walk, ped_pending, counter, cycle_start
    );
    modport slave (
        input  tick, ped_req, main_traffic_in, side_traffic_in,
        output main_light, side_light, walk, ped_pending, counter, cycle_start
    );
`endif
endinterface

// File: rtl/traffic_sequencer.sv
// traffic_sequencer
//   Intersection phase controller. Sequences the main/side signal heads and
//   the pedestrian walk phase, advancing only on the slow tick enable.
//   Traffic levels are sampled at each cycle start; the strictly busier road
//   gets EXTEND extra green ticks. Pedestrian requests are latched and served
//   after the second all-red of the cycle.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   bus    - traffic_sequencer_if.slave: tick, ped_req, main/side traffic
//            levels in; main/side lamps (one-hot {red,yellow,green}), walk,
//            ped_pending, counter (ticks since cycle start, saturating at 63),
//            cycle_start pulse out. All outputs are registered.
// Optional: define NIGHT_FLASH_EN to add the night input and FLASH state.
module traffic_sequencer #(
    parameter int BASE_GREEN = 10,
    parameter int EXTEND     = 4,
    parameter int YELLOW_LEN = 2,
    parameter int ALLRED_LEN = 2,
    parameter int WALK_LEN   = 10
) (
    input  logic                clk,
    input  logic                reset,
    traffic_sequencer_if.slave  bus
);
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
`ifdef NIGHT_FLASH_EN
    localparam logic [2:0] LAMP_OFF = 3'b000;
`endif

    localparam logic [15:0] GREEN_BASE = 16'(BASE_GREEN);
    localparam logic [15:0] GREEN_EXT  = 16'(EXTEND);
    localparam logic [15:0] YEL_LEN    = 16'(YELLOW_LEN);
    localparam logic [15:0] RED_LEN    = 16'(ALLRED_LEN);
    localparam logic [15:0] PED_LEN    = 16'(WALK_LEN);

`ifdef NIGHT_FLASH_EN
    typedef enum logic [2:0] {
        MAIN_GREEN, MAIN_YELLOW, ALLRED1, SIDE_GREEN, SIDE_YELLOW, ALLRED2, PED_WALK, FLASH
    } state_t;
`else
    typedef enum logic [2:0] {
        MAIN_GREEN, MAIN_YELLOW, ALLRED1, SIDE_GREEN, SIDE_YELLOW, ALLRED2, PED_WALK
    } state_t;
`endif

    state_t      state_reg, state_next;
    logic [15:0] timer_reg, timer_next;
    logic [5:0]  counter_reg, counter_next;
    logic [2:0]  m_reg, m_next;
    logic [2:0]  s_reg, s_next;
    logic        ped_pending_reg, ped_pending_next;
    logic        cycle_start_reg, cycle_start_next;
    logic        walk_reg, walk_next;
    logic [2:0]  main_light_reg, main_light_next;
    logic [2:0]  side_light_reg, side_light_next;
`ifdef NIGHT_FLASH_EN
    logic        flash_reg, flash_next;
`endif

    logic [15:0] phase_len;
    logic        phase_done;
    logic        cycle_begin;
    logic        enter_walk;

    // Duration of the current phase; greens use the levels sampled at cycle start.
    always_comb begin
        phase_len = 16'd1;
        case (state_reg)
            MAIN_GREEN:  phase_len = GREEN_BASE + ((m_reg > s_reg) ? GREEN_EXT : 16'd0);
            MAIN_YELLOW: phase_len = YEL_LEN;
            ALLRED1:     phase_len = RED_LEN;
            SIDE_GREEN:  phase_len = GREEN_BASE + ((s_reg > m_reg) ? GREEN_EXT : 16'd0);
            SIDE_YELLOW: phase_len = YEL_LEN;
            ALLRED2:     phase_len = RED_LEN;
            PED_WALK:    phase_len = PED_LEN;
            default:     phase_len = 16'd1;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        counter_next     = counter_reg;
        m_next           = m_reg;
        s_next           = s_reg;
        ped_pending_next = ped_pending_reg;
        cycle_start_next = 1'b0;
        cycle_begin      = 1'b0;
        enter_walk       = 1'b0;
`ifdef NIGHT_FLASH_EN
        flash_next       = flash_reg;
`endif
        phase_done = (timer_reg == phase_len - 16'd1);

        if (bus.tick) begin
            // Counts every tick except the one that opens a new cycle (cleared below).
            counter_next = (counter_reg == 6'd63) ? counter_reg : counter_reg + 6'd1;
`ifdef NIGHT_FLASH_EN
            if (state_reg == FLASH) begin
                flash_next = ~flash_reg;
                if (!bus.night) begin
                    state_next = ALLRED2;
                    timer_next = '0;
                end
            end else
`endif
            if (phase_done) begin
                timer_next = '0;
                case (state_reg)
                    MAIN_GREEN:  state_next = MAIN_YELLOW;
                    MAIN_YELLOW: state_next = ALLRED1;
                    ALLRED1:     state_next = SIDE_GREEN;
                    SIDE_GREEN:  state_next = SIDE_YELLOW;
                    SIDE_YELLOW: state_next = ALLRED2;
                    ALLRED2: begin
                        // Decision uses the already-latched request, so a press on
                        // this very tick waits for the next cycle.
                        if (ped_pending_reg) begin
                            state_next = PED_WALK;
                            enter_walk = 1'b1;
                        end else begin
                            state_next  = MAIN_GREEN;
                            cycle_begin = 1'b1;
                        end
                    end
                    PED_WALK: begin
                        state_next  = MAIN_GREEN;
                        cycle_begin = 1'b1;
                    end
                    default: state_next = MAIN_GREEN;
                endcase
            end else begin
                timer_next = timer_reg + 16'd1;
            end

            if (cycle_begin) begin
                counter_next     = '0;
                cycle_start_next = 1'b1;
                m_next           = bus.main_traffic_in;
                s_next           = bus.side_traffic_in;
`ifdef NIGHT_FLASH_EN
                if (bus.night) begin
                    state_next = FLASH;
                    flash_next = 1'b1;
                end
`endif
            end
        end

        // Serving the request takes priority over a press on the entry tick.
        if (enter_walk) begin
            ped_pending_next = 1'b0;
        end else if (bus.ped_req && (state_reg != PED_WALK)) begin
            ped_pending_next = 1'b1;
        end
    end

    // Lamp decode from the upcoming state so lamps register alongside it.
    always_comb begin
        main_light_next = LAMP_RED;
        side_light_next = LAMP_RED;
        walk_next       = 1'b0;
        case (state_next)
            MAIN_GREEN:  main_light_next = LAMP_GRN;
            MAIN_YELLOW: main_light_next = LAMP_YEL;
            SIDE_GREEN:  side_light_next = LAMP_GRN;
            SIDE_YELLOW: side_light_next = LAMP_YEL;
            PED_WALK:    walk_next       = 1'b1;
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                main_light_next = flash_next ? LAMP_YEL : LAMP_OFF;
                side_light_next = flash_next ? LAMP_RED : LAMP_OFF;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= MAIN_GREEN;
            timer_reg       <= '0;
            counter_reg     <= '0;
            m_reg           <= '0;
            s_reg           <= '0;
            ped_pending_reg <= 1'b0;
            cycle_start_reg <= 1'b0;
            walk_reg        <= 1'b0;
            main_light_reg  <= LAMP_GRN;
            side_light_reg  <= LAMP_RED;
`ifdef NIGHT_FLASH_EN
            flash_reg       <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            counter_reg     <= counter_next;
            m_reg           <= m_next;
            s_reg           <= s_next;
            ped_pending_reg <= ped_pending_next;
            cycle_start_reg <= cycle_start_next;
            walk_reg        <= walk_next;
            main_light_reg  <= main_light_next;
            side_light_reg  <= side_light_next;
`ifdef NIGHT_FLASH_EN
            flash_reg       <= flash_next;
`endif
        end
    end

    assign bus.main_light  = main_light_reg;
    assign bus.side_light  = side_light_reg;
    assign bus.walk        = walk_reg;
    assign bus.ped_pending = ped_pending_reg;
    assign bus.counter     = counter_reg;
    assign bus.cycle_start = cycle_start_reg;
endmodule

// File: tb/tb_traffic_sequencer.sv
// tb_traffic_sequencer
//   Directed, table-driven bench for traffic_sequencer with default
//   parameters, plus hand-written sequences for pedestrian timing corners,
//   slow ticks and asynchronous reset. A free-running checker watches the
//   lamp safety invariant on every clock.
module tb_traffic_sequencer;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk = 1'b0;
    logic reset;

    traffic_sequencer_if bus();

    traffic_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         adv;   // ticks to apply (one per clk)
        int         ped;   // ped_req on the first of those clks
        int         mt;
        int         st;
        logic [2:0] em;
        logic [2:0] es;
        int         ew;
        int         ep;
        int         ec;
        int         ecs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int adv, input int ped, input int mt, input int st,
                       input logic [2:0] em, input logic [2:0] es,
                       input int ew, input int ep, input int ec, input int ecs);
        vec_t v;
        v.adv = adv; v.ped = ped; v.mt = mt; v.st = st;
        v.em = em; v.es = es; v.ew = ew; v.ep = ep; v.ec = ec; v.ecs = ecs;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] em, input logic [2:0] es,
                           input int ew, input int ep, input int ec, input int ecs);
        $display("%s: main=%b side=%b walk=%b pend=%b counter=%0d cs=%b", tag,
                 bus.main_light, bus.side_light, bus.walk, bus.ped_pending,
                 bus.counter, bus.cycle_start);
        chk({tag, " main_light"},  int'(bus.main_light),  int'(em));
        chk({tag, " side_light"},  int'(bus.side_light),  int'(es));
        chk({tag, " walk"},        int'(bus.walk),        ew);
        chk({tag, " ped_pending"}, int'(bus.ped_pending), ep);
        chk({tag, " counter"},     int'(bus.counter),     ec);
        chk({tag, " cycle_start"}, int'(bus.cycle_start), ecs);
    endtask

    // ped_mode: 0 none, 1 first clk only, 2 held on every clk
    task automatic run(input int n, input int ped_mode);
        for (int i = 0; i < n; i++) begin
            bus.tick    = 1'b1;
            bus.ped_req = (ped_mode == 2) || (ped_mode == 1 && i == 0);
            @(posedge clk);
            #1;
        end
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
    endtask

    // Safety invariant: one-hot heads, never both non-red.
    always @(negedge clk) begin
        logic ok;
`ifdef NIGHT_FLASH_EN
        ok = $onehot0(bus.main_light) && $onehot0(bus.side_light);
`else
        ok = $onehot(bus.main_light) && $onehot(bus.side_light);
`endif
        ok = ok && !((bus.main_light != R) && (bus.side_light != R));
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL light_invariant: main=%b side=%b, required one-hot heads with at least one red",
                     bus.main_light, bus.side_light);
        end
    end

    initial begin
        reset               = 1'b1;
        bus.tick            = 1'b0;
        bus.ped_req         = 1'b0;
        bus.main_traffic_in = 3'd5;
        bus.side_traffic_in = 3'd2;
`ifdef NIGHT_FLASH_EN
        bus.night           = 1'b0;
`endif

        // First cycle after reset uses base lengths (sampled levels are 0).
        add( 0, 0, 5, 2, G, R, 0, 0,  0, 0);
        add( 9, 0, 5, 2, G, R, 0, 0,  9, 0);
        add( 1, 0, 5, 2, Y, R, 0, 0, 10, 0);
        add( 2, 0, 5, 2, R, R, 0, 0, 12, 0);
        add( 2, 0, 5, 2, R, G, 0, 0, 14, 0);
        add(10, 0, 5, 2, R, Y, 0, 0, 24, 0);
        add( 2, 0, 5, 2, R, R, 0, 0, 26, 0);
        add( 1, 0, 5, 2, R, R, 0, 0, 27, 0);
        add( 1, 0, 5, 2, G, R, 0, 0,  0, 1);
        // main=5 > side=2: main green 14, side green 10, 32-tick cycle
        add( 1, 0, 5, 2, G, R, 0, 0,  1, 0);
        add(12, 0, 5, 2, G, R, 0, 0, 13, 0);
        add( 1, 0, 5, 2, Y, R, 0, 0, 14, 0);
        add( 2, 0, 5, 2, R, R, 0, 0, 16, 0);
        add( 2, 0, 5, 2, R, G, 0, 0, 18, 0);
        add( 9, 0, 5, 2, R, G, 0, 0, 27, 0);
        add( 1, 0, 5, 2, R, Y, 0, 0, 28, 0);
        add( 2, 0, 5, 2, R, R, 0, 0, 30, 0);
        add( 1, 0, 5, 2, R, R, 0, 0, 31, 0);
        add( 1, 0, 5, 2, G, R, 0, 0,  0, 1);
        // inputs change to 1/6 mid-cycle: this cycle keeps 5/2 lengths
        add(13, 0, 1, 6, G, R, 0, 0, 13, 0);
        add( 1, 0, 1, 6, Y, R, 0, 0, 14, 0);
        add( 4, 0, 1, 6, R, G, 0, 0, 18, 0);
        add( 9, 0, 1, 6, R, G, 0, 0, 27, 0);
        add( 1, 0, 1, 6, R, Y, 0, 0, 28, 0);
        add( 4, 0, 1, 6, G, R, 0, 0,  0, 1);
        // main=1 < side=6: main green 10, side green 14
        add( 9, 0, 1, 6, G, R, 0, 0,  9, 0);
        add( 1, 0, 1, 6, Y, R, 0, 0, 10, 0);
        add( 4, 0, 1, 6, R, G, 0, 0, 14, 0);
        add(13, 0, 1, 6, R, G, 0, 0, 27, 0);
        add( 1, 0, 1, 6, R, Y, 0, 0, 28, 0);
        add( 2, 0, 1, 6, R, R, 0, 0, 30, 0);
        add( 2, 0, 3, 3, G, R, 0, 0,  0, 1);
        // equal levels 3/3: both greens 10; ped press during side green
        add( 9, 0, 3, 3, G, R, 0, 0,  9, 0);
        add( 1, 0, 3, 3, Y, R, 0, 0, 10, 0);
        add( 4, 0, 3, 3, R, G, 0, 0, 14, 0);
        add( 2, 1, 3, 3, R, G, 0, 1, 16, 0);
        add( 7, 0, 3, 3, R, G, 0, 1, 23, 0);
        add( 1, 0, 3, 3, R, Y, 0, 1, 24, 0);
        add( 4, 0, 3, 3, R, R, 1, 0, 28, 0);
        add( 9, 0, 3, 3, R, R, 1, 0, 37, 0);
        add( 1, 0, 3, 3, G, R, 0, 0,  0, 1);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int v = 0; v < vecs.size(); v++) begin
            bus.main_traffic_in = 3'(vecs[v].mt);
            bus.side_traffic_in = 3'(vecs[v].st);
            for (int i = 0; i < vecs[v].adv; i++) begin
                bus.tick    = 1'b1;
                bus.ped_req = (i == 0) && (vecs[v].ped != 0);
                @(posedge clk);
                #1;
            end
            bus.tick    = 1'b0;
            bus.ped_req = 1'b0;
            chk_all($sformatf("vec%0d", v), vecs[v].em, vecs[v].es, vecs[v].ew,
                    vecs[v].ep, vecs[v].ec, vecs[v].ecs);
        end

        // Press on the ALLRED2-exit tick: latched, served one cycle later.
        run(27, 0);
        chk_all("exit_tick_before", R, R, 0, 0, 27, 0);
        run(1, 1);
        chk_all("exit_tick_press", G, R, 0, 1, 0, 1);
        run(28, 0);
        chk_all("deferred_walk", R, R, 1, 0, 28, 0);
        // Button held through the whole walk: ignored, no second walk.
        run(10, 2);
        chk_all("held_during_walk", G, R, 0, 0, 0, 1);
        run(28, 0);
        chk_all("no_second_walk", G, R, 0, 0, 0, 1);

        // Tick every third clk: phases stretch by 3 clks; tick=0 holds.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 29; i++) begin
            bus.tick = (i % 3 == 2);
            @(posedge clk);
            #1;
        end
        bus.tick = 1'b0;
        chk_all("slow_tick_9", G, R, 0, 0, 9, 0);
        bus.tick = 1'b1;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        chk_all("slow_tick_10", Y, R, 0, 0, 10, 0);
        bus.ped_req = 1'b1;
        @(posedge clk);
        #1;
        bus.ped_req = 1'b0;
        chk_all("no_tick_hold_latch", Y, R, 0, 1, 10, 0);

        // Asynchronous reset during SIDE_YELLOW with a pending request.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(15, 0);
        chk_all("pre_reset_sg", R, G, 0, 0, 15, 0);
        run(1, 1);
        chk_all("pre_reset_press", R, G, 0, 1, 16, 0);
        run(8, 0);
        chk_all("pre_reset_sy", R, Y, 0, 1, 24, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", G, R, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_all("reset_held", G, R, 0, 0, 0, 0);
        run(1, 0);
        chk_all("after_reset", G, R, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
